// File: rtl/frame_stream_gen.sv
// frame_stream_gen: frame-timed vsync/href/clken pixel source fed by an upstream
// valid/ready FIFO or by an internal ramp pattern.
module frame_stream_gen #(
  parameter int DW        = 8,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int H_BLANK   = 16,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 4,
  parameter int V_FRONT   = 4,
  parameter int CLKEN_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pattern_en,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          per_frame_vsync,
  output logic          per_frame_href,
  output logic          per_frame_clken,
  output logic [DW-1:0] per_frame_data,
  output logic          frame_done,
  output logic          underflow,
  output logic          busy
);
  localparam int M1   = IMG_W > H_BLANK ? IMG_W : H_BLANK;
  localparam int M2   = M1 > V_SYNC ? M1 : V_SYNC;
  localparam int M3   = M2 > V_BACK ? M2 : V_BACK;
  localparam int MAXC = M3 > V_FRONT ? M3 : V_FRONT;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int VW   = $clog2(IMG_H) + 1;
  localparam int DVW  = $clog2(CLKEN_DIV) + 1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

  state_t          state_q, state_d;
  logic [DVW-1:0]  div_q;
  logic [CW-1:0]   c_q, c_d, lst;
  logic [VW-1:0]   v_q, v_d;
  logic            pat_q, pat_d, unf_q, unf_d;
  logic            vs_q, hr_q, ce_q, fd_q;
  logic [DW-1:0]   dat_q, pix;
  logic            tick, act, done, eol;

  assign tick     = div_q == DVW'(CLKEN_DIV - 1);
  assign act      = state_q == ACTIVE;
  assign in_ready = tick & act & ~pat_q;
  assign pix      = pat_q ? DW'(32'(v_q) * 32'(IMG_W) + 32'(c_q)) : (in_valid ? in_data : '0);

  // One shared phase counter: h_cnt while ACTIVE, tick count in every other phase.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    v_d     = v_q;
    pat_d   = pat_q;
    unf_d   = unf_q;
    done    = 1'b0;
    eol     = 1'b0;
    lst     = state_q == VSYNC  ? CW'(V_SYNC - 1)  :
              state_q == VBACK  ? CW'(V_BACK - 1)  :
              state_q == ACTIVE ? CW'(IMG_W - 1)   :
              state_q == HBLANK ? CW'(H_BLANK - 1) : CW'(V_FRONT - 1);
    if (tick) begin
      if (state_q == IDLE) begin
        if (enable) begin
          state_d = VSYNC;
          v_d     = '0;
          pat_d   = pattern_en;
          unf_d   = 1'b0;
        end
      end else if (c_q != lst) c_d = c_q + 1'b1;
      else begin
        c_d = '0;
        case (state_q)
          VSYNC:   state_d = V_BACK > 0 ? VBACK : ACTIVE;
          VBACK:   state_d = ACTIVE;
          ACTIVE:  if (H_BLANK > 0) state_d = HBLANK; else eol = 1'b1;
          HBLANK:  eol = 1'b1;
          default: begin state_d = IDLE; done = 1'b1; end
        endcase
      end
      if (eol) begin
        if (v_q == VW'(IMG_H - 1)) begin
          state_d = V_FRONT > 0 ? VFRONT : IDLE;
          done    = V_FRONT == 0;
        end else begin
          state_d = ACTIVE;
          v_d     = v_q + 1'b1;
        end
      end
      if (act && !pat_q && !in_valid) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      state_q <= IDLE;
      c_q     <= '0;
      v_q     <= '0;
      pat_q   <= 1'b0;
      unf_q   <= 1'b0;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      ce_q    <= 1'b0;
      fd_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      ce_q  <= tick & act;
      fd_q  <= done;
      if (tick) begin
        state_q <= state_d;
        c_q     <= c_d;
        v_q     <= v_d;
        pat_q   <= pat_d;
        unf_q   <= unf_d;
        vs_q    <= state_q == VSYNC;
        hr_q    <= act;
        dat_q   <= act ? pix : '0;
      end
    end
  end

  assign per_frame_vsync = vs_q;
  assign per_frame_href  = hr_q;
  assign per_frame_clken = ce_q;
  assign per_frame_data  = dat_q;
  assign frame_done      = fd_q;
  assign underflow       = unf_q;
  assign busy            = state_q != IDLE;
endmodule

// File: tb/tb_frame_stream_gen.sv
// tb_frame_stream_gen: scoreboard bench for two frame_stream_gen configurations
// (divided ticks with blanking, and every-cycle ticks with back-to-back lines).
module tb_frame_stream_gen;
  typedef struct packed {logic uf; logic [7:0] rdy;} fr_t;

  logic       clk = 1'b0;
  logic       rstn [2] = '{1'b1, 1'b1};
  logic       en [2] = '{1'b0, 1'b0};
  logic       pen [2] = '{1'b0, 1'b0};
  logic       iv_a = 1'b0;
  logic [7:0] id_a = 8'h00;
  logic       rdy [2], vs [2], hr [2], ce [2], fd [2], uf [2], bz [2];
  logic [7:0] dat [2];

  logic [7:0] exp_q [2][$];
  fr_t        exp_fr [2][$];
  logic [8:0] slot_q [$];

  int   total = 0, bad = 0, cyc = 0;
  int   starts [2] = '{0, 0};
  int   frames [2] = '{0, 0};
  int   n_vs [2] = '{0, 0};
  int   n_hr [2] = '{0, 0};
  int   n_win [2] = '{0, 0};
  int   n_ce [2] = '{0, 0};
  int   n_rdy [2] = '{0, 0};
  int   last_fd [2] = '{-1, -1};
  int   exp_starts [2] = '{0, 0};
  int   exp_frames [2] = '{0, 0};
  logic vs_p [2] = '{1'b0, 1'b0};
  logic hr_p [2] = '{1'b0, 1'b0};
  bit   took = 0, to_flag = 0, to_seen = 0, fin_req = 0, fin_seen = 0;
  fr_t  f;
  logic [7:0] e;

  always #5 clk = ~clk;

  frame_stream_gen #(.DW(8), .IMG_W(4), .IMG_H(3), .H_BLANK(2), .V_SYNC(1), .V_BACK(1),
                     .V_FRONT(1), .CLKEN_DIV(2)) dut_a (
    .clk(clk), .rst_n(rstn[0]), .enable(en[0]), .pattern_en(pen[0]),
    .in_data(id_a), .in_valid(iv_a), .in_ready(rdy[0]),
    .per_frame_vsync(vs[0]), .per_frame_href(hr[0]), .per_frame_clken(ce[0]),
    .per_frame_data(dat[0]), .frame_done(fd[0]), .underflow(uf[0]), .busy(bz[0]));

  frame_stream_gen #(.DW(8), .IMG_W(4), .IMG_H(3), .H_BLANK(0), .V_SYNC(1), .V_BACK(0),
                     .V_FRONT(1), .CLKEN_DIV(1)) dut_b (
    .clk(clk), .rst_n(rstn[1]), .enable(en[1]), .pattern_en(pen[1]),
    .in_data(8'h00), .in_valid(1'b0), .in_ready(rdy[1]),
    .per_frame_vsync(vs[1]), .per_frame_href(hr[1]), .per_frame_clken(ce[1]),
    .per_frame_data(dat[1]), .frame_done(fd[1]), .underflow(uf[1]), .busy(bz[1]));

  function automatic int div_of(input int d);
    return d == 0 ? 2 : 1;
  endfunction

  // Ticks from first VSYNC tick through last VFRONT tick, straight from the phase lengths.
  function automatic int frame_ticks(input int d);
    return d == 0 ? 1 + 1 + 3 * (4 + 2) + 1 : 1 + 0 + 3 * (4 + 0) + 1;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at cycle %0d", nm, d, act, want, cyc);
    end
  endtask

  task automatic push_pattern(input int d);
    for (int k = 0; k < 12; k++) exp_q[d].push_back(8'(k));
    exp_fr[d].push_back('{uf: 1'b0, rdy: 8'd0});
  endtask

  // mode 0: valid pixels 10h.., mode 1: 20h.. with pixel 2 of line 1 missing, mode 2: random.
  task automatic push_up(input int mode);
    logic       v;
    logic [7:0] dv;
    logic       any_miss = 1'b0;
    for (int k = 0; k < 12; k++) begin
      v  = mode == 0 ? 1'b1 : mode == 1 ? (k != 6) : ($urandom_range(3) != 0);
      dv = mode == 0 ? 8'h10 + 8'(k) : mode == 1 ? 8'h20 + 8'(k) : 8'($urandom);
      slot_q.push_back({v, dv});
      exp_q[0].push_back(v ? dv : 8'h00);
      any_miss = any_miss | !v;
    end
    exp_fr[0].push_back('{uf: any_miss, rdy: 8'd12});
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Upstream source: in_ready seen now means the presented slot is consumed at the next edge.
  always @(negedge clk) begin
    if (took && slot_q.size() > 0) void'(slot_q.pop_front());
    {iv_a, id_a} = slot_q.size() > 0 ? slot_q[0] : 9'h000;
    took = rdy[0];
  end

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rstn[d]) begin
        chk("reset_outputs", d, {17'h0, rdy[d], vs[d], hr[d], ce[d], fd[d], uf[d], bz[d], dat[d]}, 32'h0);
        vs_p[d]    = 1'b0;
        hr_p[d]    = 1'b0;
        last_fd[d] = -1;
      end else begin
        if (vs[d] && !vs_p[d]) begin
          starts[d]++;
          n_vs[d] = 0; n_hr[d] = 0; n_win[d] = 0; n_ce[d] = 0; n_rdy[d] = 0;
          chk("underflow_cleared", d, 32'(uf[d]), 32'h0);
        end
        if (vs[d]) n_vs[d]++;
        if (hr[d]) n_hr[d]++;
        if (hr[d] && !hr_p[d]) n_win[d]++;
        if (rdy[d]) n_rdy[d]++;
        if (vs[d] || hr[d] || ce[d]) chk("busy_in_frame", d, 32'(bz[d]), 32'h1);
        if (ce[d]) begin
          n_ce[d]++;
          chk("href_with_clken", d, 32'(hr[d]), 32'h1);
          chk("pixel_queue", d, 32'(exp_q[d].size() > 0), 32'h1);
          if (exp_q[d].size() > 0) begin
            e = exp_q[d].pop_front();
            chk("pixel_data", d, 32'(dat[d]), 32'(e));
          end
        end
        if (fd[d]) begin
          frames[d]++;
          chk("clken_count", d, n_ce[d], 12);
          chk("href_clks", d, n_hr[d], 12 * div_of(d));
          chk("href_windows", d, n_win[d], d == 0 ? 3 : 1);
          chk("vsync_clks", d, n_vs[d], div_of(d));
          chk("busy_at_done", d, 32'(bz[d]), 32'h0);
          chk("frame_queue", d, 32'(exp_fr[d].size() > 0), 32'h1);
          if (exp_fr[d].size() > 0) begin
            f = exp_fr[d].pop_front();
            chk("underflow_at_done", d, 32'(uf[d]), 32'(f.uf));
            chk("in_ready_count", d, n_rdy[d], 32'(f.rdy));
          end
          if (last_fd[d] >= 0) chk("frame_period", d, cyc - last_fd[d], (frame_ticks(d) + 1) * div_of(d));
          last_fd[d] = cyc;
        end
        vs_p[d] = vs[d];
        hr_p[d] = hr[d];
      end
    end
    if (to_flag && !to_seen) begin
      to_seen = 1;
      chk("watchdog", 0, 32'(to_flag), 32'h0);
    end
    if (fin_req && !fin_seen) begin
      fin_seen = 1;
      chk("slots_left", 0, slot_q.size(), 0);
      for (int d = 0; d < 2; d++) begin
        chk("pixels_left", d, exp_q[d].size(), 0);
        chk("frames_left", d, exp_fr[d].size(), 0);
        chk("frame_starts", d, starts[d], exp_starts[d]);
        chk("frames_done", d, frames[d], exp_frames[d]);
        chk("busy_idle", d, 32'(bz[d]), 32'h0);
      end
    end
  end

  initial begin
    repeat (30000) @(negedge clk);
    to_flag = 1;
    repeat (2) @(negedge clk);
    finish_run();
  end

  initial begin
    #1 rstn = '{1'b0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      push_pattern(0);
      push_pattern(1);
    end
    push_up(0);
    push_up(1);
    push_up(2);
    repeat (3) @(negedge clk);
    rstn = '{1'b1, 1'b1};
    en   = '{1'b1, 1'b1};
    pen  = '{1'b1, 1'b1};
    wait (starts[1] == 2);
    en[1] = 1'b0;
    wait (starts[0] == 2);
    pen[0] = 1'b0;
    wait (starts[0] == 5 && n_win[0] == 2);
    en[0] = 1'b0;
    wait (frames[0] == 5);
    repeat (60) @(negedge clk);
    push_pattern(0);
    pen[0] = 1'b1;
    en[0]  = 1'b1;
    wait (starts[0] == 6 && n_win[0] == 2);
    @(posedge clk);
    #1 rstn[0] = 1'b0;
    exp_q[0].delete();
    exp_fr[0].delete();
    push_pattern(0);
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    wait (starts[0] == 7);
    en[0] = 1'b0;
    wait (frames[0] == 6);
    repeat (60) @(negedge clk);
    exp_starts = '{7, 2};
    exp_frames = '{6, 2};
    fin_req = 1;
    repeat (2) @(negedge clk);
    finish_run();
  end
endmodule

// File: doc/frame_stream_gen.md
Name: frame_stream_gen

Overview:
- Frame-timed pixel stream source.
- Emits per_frame_vsync, per_frame_href, per_frame_clken and per_frame_data in the format our line shift RAM and 3x3 window stages consume.
- Sits between a pixel FIFO (valid/ready) or its internal test pattern and the image-processing pipeline.
- Also serves as the standard stimulus source for pipeline benches.

Parameters:
- DW, 8, pixel data width
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- H_BLANK, 16, blank ticks after every active line, including the last
- V_SYNC, 4, vsync ticks at frame start
- V_BACK, 4, blank ticks between vsync and first line
- V_FRONT, 4, blank ticks after the last line's H_BLANK
- CLKEN_DIV, 2, clk cycles per tick; legal range is 1 or more

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- enable, input, 1, level; sampled in IDLE to start a frame
- pattern_en, input, 1, 1 = internal ramp data, 0 = upstream data; sampled at frame start
- in_data, input, DW, upstream pixel
- in_valid, input, 1, upstream pixel valid
- in_ready, output, 1, pixel taken this cycle (combinational)
- per_frame_vsync, output, 1, frame sync
- per_frame_href, output, 1, line valid
- per_frame_clken, output, 1, one-cycle pixel strobe
- per_frame_data, output, DW, pixel
- frame_done, output, 1, one-cycle pulse at frame end
- underflow, output, 1, sticky: a pixel slot found in_valid low
- busy, output, 1, high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: every output is 0; state is IDLE; all counters are 0. Reset asserted mid-frame aborts immediately with no frame_done.
- Tick generator:
  - A divider counter of 0..CLKEN_DIV-1 free-runs from reset.
  - tick is high when the counter equals CLKEN_DIV-1.
  - With CLKEN_DIV=1, tick is high every cycle.
- All state, counter and timing-output updates happen only on tick cycles, except the per_frame_clken and frame_done pulses.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
  - IDLE to VSYNC: on a tick with enable=1. pattern_en is latched at this point.
  - VSYNC lasts V_SYNC ticks, then goes to VBACK.
  - VBACK lasts V_BACK ticks, then goes to ACTIVE.
  - ACTIVE lasts IMG_W ticks. h_cnt runs 0..IMG_W-1. It then goes to HBLANK.
  - HBLANK lasts H_BLANK ticks. It then goes to ACTIVE with v_cnt+1, or to VFRONT if v_cnt = IMG_H-1.
  - VFRONT lasts V_FRONT ticks, then goes to IDLE.
  - A zero-length phase (V_BACK, H_BLANK or V_FRONT = 0) is skipped.
- Back-to-back frames: frame_done pulses for one clk together with the registered update at the last VFRONT tick. If enable is still 1 at the next tick, a new VSYNC starts; the gap is exactly one IDLE tick.
- Enable dropped mid-frame: the current frame completes, then the block stays in IDLE.
- Output registers (updated on tick, visible one clk after the tick):
  - per_frame_vsync = (state==VSYNC)
  - per_frame_href = (state==ACTIVE)
  - per_frame_data = the pixel taken in that tick in ACTIVE, else 0
  - per_frame_clken = 1 for exactly one clk after each ACTIVE tick, else 0
  - vsync and href therefore hold between ticks.
- Upstream handshake:
  - in_ready = tick & (state==ACTIVE) & !pattern_latched.
  - The pixel is consumed when in_ready & in_valid.
  - If in_valid=0 at an ACTIVE tick: data output is 0, underflow is set, and timing does not stall.
  - underflow clears only on reset or at an IDLE-to-VSYNC transition.
- Pattern mode:
  - data = (v_cnt*IMG_W + h_cnt) truncated to DW.
  - in_ready stays 0, and underflow never sets.
- Counter widths: $clog2 of the respective maximum plus 1; no wrap within legal parameters.

Test Plan:
Small parameters for all scenarios: IMG_W=4, IMG_H=3, H_BLANK=2, V_SYNC=1, V_BACK=1, V_FRONT=1, CLKEN_DIV=2.

- Reset then enable=1, pattern_en=1:
  - vsync is high for 2 clk.
  - 3 href windows of 8 clk each, separated by 4 clk.
  - clken pulses carry data 0..11 in order, 12 pulses total.
  - frame_done fires once per 42 clk of frame; next vsync follows after 2 clk.
  - underflow stays 0.
- pattern_en=0 with in_valid held 1 and in_data incrementing on each handshake from 8'h10:
  - in_ready pulses 12 times per frame.
  - Output data is 10h..1Bh; underflow=0.
- pattern_en=0 with in_valid=0 during the 3rd pixel of line 1:
  - That clken carries 0 and the rest are unchanged.
  - underflow latches 1 and clears at the next frame start.
- enable dropped during line 1:
  - The frame finishes with all 12 pixels; one frame_done.
  - busy falls and no further vsync appears.
- rst_n pulsed low mid-line:
  - All outputs are 0 asynchronously.
  - After release with enable=1, a full frame restarts from vsync.
- CLKEN_DIV=1, H_BLANK=0, V_BACK=0:
  - clken is continuous across each line.
  - href drops only at the frame level, with lines back-to-back.
  - 12 data values 0..11.
